// File: rtl/apb_bridge_pkg.sv
// Shared FSM state type and default sizing for the two-client APB memory bridge.
package apb_bridge_pkg;

    localparam int APB_ASIZE     = 32;
    localparam int APB_DSIZE     = 32;
    localparam int APB_MEM_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    function automatic logic [1:0] onehot2(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant flag only advances when en_i accepts a grant.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic last_q, last_d;

    // last_q = 1 means req1 won last, so req0 takes the first contest out of reset
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    assign last_d = (en_i && (req_i != 2'b00)) ? gnt_o[1] : last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) last_q <= 1'b1;
        else         last_q <= last_d;
    end

endmodule

// File: rtl/apb_mem_arbiter.sv
// Shares one APB slave memory between two requesters: round-robin grant,
// SETUP/ACCESS sequencing, address range check and a one-cycle response pulse.
module apb_mem_arbiter
    import apb_bridge_pkg::*;
#(
    parameter int ASIZE     = APB_ASIZE,
    parameter int DSIZE     = APB_DSIZE,
    parameter int MEM_DEPTH = APB_MEM_DEPTH
) (
    input  logic               Pclk,
    input  logic               Presetn,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [1:0]         req_write,
    input  logic [2*ASIZE-1:0] req_addr,
    input  logic [2*DSIZE-1:0] req_wdata,
    output logic [1:0]         rsp_valid,
    output logic               rsp_err,
    output logic [DSIZE-1:0]   rsp_rdata,
    output logic               Psel,
    output logic               Penable,
    output logic               Pwrite,
    output logic [ASIZE-1:0]   Paddr,
    output logic [DSIZE-1:0]   Pdata,
    input  logic [DSIZE-1:0]   memory_out
);

    localparam logic [ASIZE-1:0] DEPTH_A = ASIZE'(MEM_DEPTH);

    apb_state_e       state_q, state_d;
    logic [1:0]       gnt;
    logic             idle, take, sel, sel_write, sel_err;
    logic [ASIZE-1:0] sel_addr;
    logic [DSIZE-1:0] sel_wdata;

    logic             gsel_q, write_q, err_q;
    logic [ASIZE-1:0] paddr_q;
    logic [DSIZE-1:0] pdata_q, rdata_q;

    rr_arb2 u_arb (
        .clk_i  (Pclk),
        .rst_ni (Presetn),
        .req_i  (req_valid),
        .en_i   (idle),
        .gnt_o  (gnt)
    );

    assign idle      = (state_q == IDLE);
    assign take      = idle && (gnt != 2'b00);
    assign sel       = gnt[1];
    assign sel_write = req_write[sel];
    assign sel_addr  = sel ? req_addr[2*ASIZE-1:ASIZE]  : req_addr[ASIZE-1:0];
    assign sel_wdata = sel ? req_wdata[2*DSIZE-1:DSIZE] : req_wdata[DSIZE-1:0];
    // full-width unsigned compare: high address bits must never alias a legal word
    assign sel_err   = (sel_addr >= DEPTH_A);

    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = sel_err ? RESP : SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Psel      = 1'b0;
        Penable   = 1'b0;
        Pwrite    = 1'b0;
        rsp_valid = 2'b00;
        rsp_err   = 1'b0;
        case (state_q)
            SETUP: begin
                Psel   = 1'b1;
                Pwrite = write_q;
            end
            ACCESS: begin
                Psel    = 1'b1;
                Penable = 1'b1;
                Pwrite  = write_q;
            end
            RESP: begin
                rsp_valid = onehot2(gsel_q);
                rsp_err   = err_q;
            end
            default: ;
        endcase
    end

    // Paddr/Pdata only move on a legal grant so the bus stays quiet around error responses
    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            gsel_q  <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            paddr_q <= '0;
            pdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (take) begin
                gsel_q  <= sel;
                write_q <= sel_write;
                err_q   <= sel_err;
                if (sel_err) begin
                    rdata_q <= '0;
                end else begin
                    paddr_q <= sel_addr;
                    pdata_q <= sel_wdata;
                end
            end
            if (state_q == ACCESS) rdata_q <= write_q ? '0 : memory_out;
        end
    end

    // gated by reset so a requester holding valid through reset sees no grant
    assign req_ready = (idle && Presetn) ? gnt : 2'b00;
    assign Paddr     = paddr_q;
    assign Pdata     = pdata_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_apb_mem_arbiter.sv
// Bench for apb_mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_apb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MD = 16;

    logic            Pclk = 1'b0;
    logic            Presetn;
    logic [1:0]      req_valid, req_ready, req_write, rsp_valid;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic            rsp_err, Psel, Penable, Pwrite;
    logic [DW-1:0]   rsp_rdata, Pdata, memory_out;
    logic [AW-1:0]   Paddr;

    always #5 Pclk = ~Pclk;

    apb_mem_arbiter #(.ASIZE(AW), .DSIZE(DW), .MEM_DEPTH(MD)) dut (
        .Pclk(Pclk), .Presetn(Presetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .Psel(Psel), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pdata(Pdata), .memory_out(memory_out)
    );

    // APB slave memory: writes on every edge Pwrite is high, registered read data
    logic [DW-1:0] smem [MD];
    always @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            for (int i = 0; i < MD; i++) smem[i] <= '0;
            memory_out <= '0;
        end else begin
            if (Pwrite && Paddr < AW'(MD)) smem[Paddr[3:0]] <= Pdata;
            if (!Pwrite && Paddr < AW'(MD)) memory_out <= smem[Paddr[3:0]];
        end
    end

    int n_cmp = 0, n_bad = 0, cyc = 0;

    // reference model: memory contents, arbitration history, one in-flight transaction
    logic [DW-1:0] mem_m [MD];
    int            last_m;
    bit            pend, p_wr, p_err;
    int            p_g, p_t0;
    logic [AW-1:0] p_addr, addr_m;
    logic [DW-1:0] p_data, data_m, rdata_m;
    int            dq[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < MD; i++) mem_m[i] = '0;
        last_m = 1; pend = 0; addr_m = '0; data_m = '0; rdata_m = '0;
    endtask

    task automatic set_req(input int r, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[r] = 1'b1;
        req_write[r] = wr;
        req_addr[r*AW +: AW]  = a;
        req_wdata[r*DW +: DW] = d;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return AW'(MD) + AW'($urandom_range(0, 3));
            1:       return $urandom | 32'h8000_0000;
            2:       return 32'h0000_0010 | AW'($urandom_range(0, 15));
            default: return AW'($urandom_range(0, MD - 1));
        endcase
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_rsp"},   64'(rsp_valid), 64'(0));
        chk({tag, "_err"},   64'(rsp_err),   64'(0));
        chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(0));
        chk({tag, "_apb"},   64'({Psel, Penable, Pwrite}), 64'(0));
        chk({tag, "_paddr"}, 64'(Paddr), 64'(0));
        chk({tag, "_pdata"}, 64'(Pdata), 64'(0));
    endtask

    task automatic chk_mem(input string tag);
        for (int i = 0; i < MD; i++) chk(tag, 64'(smem[i]), 64'(mem_m[i]));
    endtask

    // one clock: compare every output with the model at negedge, then advance
    task automatic cycle();
        logic [1:0] e_rdy, e_rsp, rdy;
        logic       e_sel, e_en, e_wr, e_err;
        int         g, d;
        bit         grant, done;
        e_rdy = '0; e_rsp = '0; e_sel = 0; e_en = 0; e_wr = 0; e_err = 0;
        g = 0; grant = 0; done = 0;
        @(negedge Pclk);
        cyc++;
        d = cyc - p_t0;
        if (!pend) begin
            if (req_valid != 2'b00) begin
                g = (req_valid == 2'b11) ? 1 - last_m : (req_valid[1] ? 1 : 0);
                e_rdy[g] = 1'b1;
                grant = 1;
            end
        end else if (p_err || d >= 3) begin
            e_rsp[p_g] = 1'b1;
            e_err = p_err;
            rdata_m = (p_err || p_wr) ? '0 : mem_m[p_addr[3:0]];
            done = 1;
        end else begin
            e_sel = 1; e_en = (d == 2); e_wr = p_wr;
        end
        chk("ready",   64'(req_ready), 64'(e_rdy));
        chk("psel",    64'(Psel),      64'(e_sel));
        chk("penable", 64'(Penable),   64'(e_en));
        chk("pwrite",  64'(Pwrite),    64'(e_wr));
        chk("rsp",     64'(rsp_valid), 64'(e_rsp));
        if (e_rsp != 2'b00) chk("rsp_err", 64'(rsp_err), 64'(e_err));
        chk("rdata",   64'(rsp_rdata), 64'(rdata_m));
        chk("paddr",   64'(Paddr),     64'(addr_m));
        chk("pdata",   64'(Pdata),     64'(data_m));
        if (req_ready != 2'b00) dq.push_back(int'(req_ready[1]));
        if (done) begin
            if (p_wr && !p_err) mem_m[p_addr[3:0]] = p_data;
            pend = 0;
        end
        if (grant) begin
            pend   = 1;
            p_g    = g;
            p_wr   = req_write[g];
            p_addr = req_addr[g*AW +: AW];
            p_data = req_wdata[g*DW +: DW];
            p_err  = (p_addr >= AW'(MD));
            p_t0   = cyc;
            last_m = g;
            if (!p_err) begin addr_m = p_addr; data_m = p_data; end
        end
        rdy = req_ready;
        @(posedge Pclk);
        #1;
        if (rdy[0]) req_valid[0] = 1'b0;
        if (rdy[1]) req_valid[1] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((req_valid != 2'b00 || pend) && n < 60) begin
            cycle();
            n++;
        end
        if (req_valid != 2'b00 || pend) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: still busy after %0d cycles, want idle", n);
        end
        cycle();
    endtask

    initial begin
        int n;
        Presetn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        model_reset();
        #3 chk_zero("reset");
        @(posedge Pclk); @(posedge Pclk); #1 Presetn = 1'b1;

        // write then read back through the other requester
        set_req(0, 1'b1, 32'd3, 32'hDEAD_BEEF); drain();
        set_req(1, 1'b0, 32'd3, 32'h0);         drain();

        // both requesters valid continuously: strict alternation starting with req0
        dq.delete();
        set_req(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, MD - 1)), $urandom);
        set_req(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, MD - 1)), $urandom);
        n = 0;
        while (dq.size() < 4 && n < 40) begin
            cycle();
            n++;
            if (dq.size() < 4) begin
                for (int r = 0; r < 2; r++)
                    if (!req_valid[r])
                        set_req(r, 1'($urandom_range(0, 1)), AW'($urandom_range(0, MD - 1)), $urandom);
            end
        end
        req_valid = '0;
        drain();
        if (dq.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("order", 64'(dq[i]), 64'(i % 2));
        end else begin
            n_cmp++; n_bad++;
            $display("FAIL order: got %0d grants want 4", dq.size());
        end

        // out-of-range: first illegal word, and one that would alias word 3 if truncated
        set_req(0, 1'b0, 32'd16, 32'h0);          drain();
        set_req(1, 1'b1, 32'h13, 32'hBAD0_BAD0);  drain();
        chk_mem("mem_err");

        // reset asserted during ACCESS of a write
        set_req(0, 1'b1, 32'd7, 32'h1234_5678);
        n = 0;
        while (!(pend && (cyc - p_t0) == 1) && n < 10) begin cycle(); n++; end
        if (!(pend && (cyc - p_t0) == 1)) begin
            n_cmp++; n_bad++;
            $display("FAIL access_wait: got no transfer in ACCESS want one");
        end
        #2 Presetn = 1'b0;
        #1 chk_zero("async_rst");
        model_reset();
        req_valid = '0;
        @(posedge Pclk); @(posedge Pclk); #1 Presetn = 1'b1;
        chk_mem("mem_clr");
        set_req(1, 1'b1, 32'd9, 32'hA5A5_0009); drain();
        set_req(0, 1'b0, 32'd9, 32'h0);         drain();

        // idle bus, then a read of a never-written word
        repeat (20) cycle();
        set_req(0, 1'b0, 32'd5, 32'h0); drain();

        // random traffic with withdrawals while not granted
        repeat (600) begin
            for (int r = 0; r < 2; r++) begin
                if (!req_valid[r] && $urandom_range(0, 2) == 0)
                    set_req(r, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
                else if (req_valid[r] && $urandom_range(0, 11) == 0)
                    req_valid[r] = 1'b0;
            end
            cycle();
        end
        drain();
        chk_mem("mem_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
